// File: rtl/el2_regfile_snapshot_pkg.sv
// rtl/el2_regfile_snapshot_pkg.sv - register index map and FSM state type for the snapshot controller
package el2_pkg;

   localparam int RF_IDX_RA        = 0;
   localparam int RF_IDX_SP        = 1;
   localparam int RF_IDX_FP        = 2;
   localparam int RF_IDX_A0        = 3;
   localparam int RF_IDX_A1        = 4;
   localparam int RF_IDX_A2        = 5;
   localparam int RF_IDX_A3        = 6;
   localparam int RF_IDX_A4        = 7;
   localparam int RF_IDX_A5        = 8;
   localparam int RF_IDX_A6        = 9;
   localparam int RF_IDX_A7        = 10;
   localparam int RF_IDX_PC        = 11;
   localparam int RF_IDX_NPC       = 12;
   localparam int RF_IDX_MSTATUS   = 13;
   localparam int RF_IDX_MIE       = 14;
   localparam int RF_IDX_MTVEC     = 15;
   localparam int RF_IDX_MSCRATCH  = 16;
   localparam int RF_IDX_MEPC      = 17;
   localparam int RF_IDX_MCAUSE    = 18;
   localparam int RF_IDX_MTVAL     = 19;
   localparam int RF_IDX_MIP       = 20;
   localparam int RF_IDX_MCYCLEL   = 21;
   localparam int RF_IDX_MCYCLEH   = 22;
   localparam int RF_IDX_MINSTRETL = 23;
   localparam int RF_IDX_MINSTRETH = 24;
   localparam int RF_IDX_MRAC      = 25;
   localparam int RF_SNAP_NUM      = 26;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      GAP    = 2'd2
   } el2_rf_snap_state_t;

endpackage

// File: rtl/el2_regfile_snapshot_if.sv
// rtl/el2_regfile_snapshot_if.sv - exposed architectural register set (11 GPRs, 15 PC/CSR words)
interface el2_regfile_if;

   logic [31:0] ra, sp, fp;
   logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
   logic [31:0] pc, npc, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip;
   logic [31:0] mcyclel, mcycleh, minstretl, minstreth, mrac;

   modport veer_rf_source (
      output ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7,
             pc, npc, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
             mcyclel, mcycleh, minstretl, minstreth, mrac
   );

   modport veer_rf_sink (
      input  ra, sp, fp, a0, a1, a2, a3, a4, a5, a6, a7,
             pc, npc, mstatus, mie, mtvec, mscratch, mepc, mcause, mtval, mip,
             mcyclel, mcycleh, minstretl, minstreth, mrac
   );

endinterface

// File: rtl/el2_regfile_snapshot_penc.sv
// rtl/el2_regfile_snapshot_penc.sv - find-first-set over the pending word mask
module el2_rf_snap_penc
   import el2_pkg::*;
(
   input  logic [RF_SNAP_NUM-1:0] vec,
   output logic [4:0]             idx,
   output logic                   any,
   output logic                   one_left
);

   always_comb begin
      idx = '0;
      for (int i = RF_SNAP_NUM - 1; i >= 0; i--) begin
         if (vec[i]) idx = 5'(i);
      end
   end

   assign any      = |vec;
   // clearing the lowest set bit leaves nothing exactly when one bit was set
   assign one_left = any && ((vec & (vec - 26'd1)) == '0);

endmodule

// File: rtl/el2_regfile_snapshot.sv
// rtl/el2_regfile_snapshot.sv - trigger-driven atomic capture of the register set, streamed one word per beat
module el2_regfile_snapshot
   import el2_pkg::*;
#(
   parameter int unsigned MIN_GAP = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   el2_regfile_if.veer_rf_sink    rf,
   input  logic                   req_trap,
   input  logic                   req_sw,
   input  logic [RF_SNAP_NUM-1:0] mask,
   input  logic                   drop_clr,
   output logic                   busy,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4:0]             out_idx,
   output logic [31:0]            out_data,
   output logic                   out_last,
   output logic                   out_src,
   output logic [7:0]             drop_cnt
);

   el2_rf_snap_state_t    state_q, state_d;
   logic [RF_SNAP_NUM-1:0] pend_q, pend_d;
   logic                   src_q, src_d;
   logic [7:0]             gap_q, gap_d;
   logic [7:0]             drop_q, drop_d;
   logic [31:0]            shadow_q [RF_SNAP_NUM];
   logic [31:0]            rf_words [RF_SNAP_NUM];

   logic                   accept;
   logic [1:0]             ntrig, ndrop;
   logic [8:0]             drop_sum;
   logic [4:0]             sel_idx;
   logic                   sel_any, sel_one;

   assign rf_words[RF_IDX_RA]        = rf.ra;
   assign rf_words[RF_IDX_SP]        = rf.sp;
   assign rf_words[RF_IDX_FP]        = rf.fp;
   assign rf_words[RF_IDX_A0]        = rf.a0;
   assign rf_words[RF_IDX_A1]        = rf.a1;
   assign rf_words[RF_IDX_A2]        = rf.a2;
   assign rf_words[RF_IDX_A3]        = rf.a3;
   assign rf_words[RF_IDX_A4]        = rf.a4;
   assign rf_words[RF_IDX_A5]        = rf.a5;
   assign rf_words[RF_IDX_A6]        = rf.a6;
   assign rf_words[RF_IDX_A7]        = rf.a7;
   assign rf_words[RF_IDX_PC]        = rf.pc;
   assign rf_words[RF_IDX_NPC]       = rf.npc;
   assign rf_words[RF_IDX_MSTATUS]   = rf.mstatus;
   assign rf_words[RF_IDX_MIE]       = rf.mie;
   assign rf_words[RF_IDX_MTVEC]     = rf.mtvec;
   assign rf_words[RF_IDX_MSCRATCH]  = rf.mscratch;
   assign rf_words[RF_IDX_MEPC]      = rf.mepc;
   assign rf_words[RF_IDX_MCAUSE]    = rf.mcause;
   assign rf_words[RF_IDX_MTVAL]     = rf.mtval;
   assign rf_words[RF_IDX_MIP]       = rf.mip;
   assign rf_words[RF_IDX_MCYCLEL]   = rf.mcyclel;
   assign rf_words[RF_IDX_MCYCLEH]   = rf.mcycleh;
   assign rf_words[RF_IDX_MINSTRETL] = rf.minstretl;
   assign rf_words[RF_IDX_MINSTRETH] = rf.minstreth;
   assign rf_words[RF_IDX_MRAC]      = rf.mrac;

   el2_rf_snap_penc u_penc (
      .vec      (pend_q),
      .idx      (sel_idx),
      .any      (sel_any),
      .one_left (sel_one)
   );

   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == STREAM) && sel_any;
   assign out_idx   = out_valid ? sel_idx : 5'd0;
   assign out_data  = out_valid ? shadow_q[sel_idx] : 32'd0;
   assign out_last  = out_valid && sel_one;
   assign out_src   = src_q;
   assign drop_cnt  = drop_q;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      src_d   = src_q;
      gap_d   = gap_q;
      accept  = 1'b0;
      ntrig   = {1'b0, req_trap} + {1'b0, req_sw};
      ndrop   = ntrig;
      unique case (state_q)
         IDLE: begin
            if ((req_trap || req_sw) && (mask != '0)) begin
               accept  = 1'b1;
               pend_d  = mask;
               src_d   = req_trap;
               state_d = STREAM;
               // only the losing sw request is lost on a simultaneous accept
               ndrop   = (req_trap && req_sw) ? 2'd1 : 2'd0;
            end
         end
         STREAM: begin
            if (out_valid && out_ready) begin
               pend_d = pend_q & ~(26'd1 << sel_idx);
               if (sel_one) begin
                  if (MIN_GAP > 0) begin
                     state_d = GAP;
                     gap_d   = 8'(MIN_GAP - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         GAP: begin
            if (gap_q == 8'd0) state_d = IDLE;
            else               gap_d   = gap_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
      drop_sum = {1'b0, drop_q} + {7'd0, ndrop};
      if (drop_clr)              drop_d = 8'd0;
      else if (drop_sum > 9'd255) drop_d = 8'hFF;
      else                       drop_d = drop_sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         pend_q  <= '0;
         src_q   <= 1'b0;
         gap_q   <= 8'd0;
         drop_q  <= 8'd0;
         for (int i = 0; i < RF_SNAP_NUM; i++) shadow_q[i] <= 32'd0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         src_q   <= src_d;
         gap_q   <= gap_d;
         drop_q  <= drop_d;
         if (accept) begin
            for (int i = 0; i < RF_SNAP_NUM; i++) shadow_q[i] <= rf_words[i];
         end
      end
   end

endmodule

// File: tb/tb_el2_regfile_snapshot.sv
// tb/tb_el2_regfile_snapshot.sv - directed bench with a queue-based snapshot model checked every cycle
module tb_el2_regfile_snapshot;

   localparam int unsigned MIN_GAP = 4;

   typedef struct {
      logic [4:0]  idx;
      logic [31:0] data;
      logic        last;
      logic        src;
   } beat_t;

   logic        clk, rst;
   logic        req_trap, req_sw, drop_clr, out_ready;
   logic [25:0] mask;
   logic        busy, out_valid, out_last, out_src;
   logic [4:0]  out_idx;
   logic [31:0] out_data;
   logic [7:0]  drop_cnt;
   logic [31:0] rf_val [26];

   int tests_run = 0;
   int failed    = 0;
   bit chk_en    = 0;

   beat_t mq[$];
   beat_t log_q[$];
   int    mgap  = 0;
   int    mdrop = 0;

   el2_regfile_if rf_bus ();

   assign rf_bus.ra        = rf_val[0];
   assign rf_bus.sp        = rf_val[1];
   assign rf_bus.fp        = rf_val[2];
   assign rf_bus.a0        = rf_val[3];
   assign rf_bus.a1        = rf_val[4];
   assign rf_bus.a2        = rf_val[5];
   assign rf_bus.a3        = rf_val[6];
   assign rf_bus.a4        = rf_val[7];
   assign rf_bus.a5        = rf_val[8];
   assign rf_bus.a6        = rf_val[9];
   assign rf_bus.a7        = rf_val[10];
   assign rf_bus.pc        = rf_val[11];
   assign rf_bus.npc       = rf_val[12];
   assign rf_bus.mstatus   = rf_val[13];
   assign rf_bus.mie       = rf_val[14];
   assign rf_bus.mtvec     = rf_val[15];
   assign rf_bus.mscratch  = rf_val[16];
   assign rf_bus.mepc      = rf_val[17];
   assign rf_bus.mcause    = rf_val[18];
   assign rf_bus.mtval     = rf_val[19];
   assign rf_bus.mip       = rf_val[20];
   assign rf_bus.mcyclel   = rf_val[21];
   assign rf_bus.mcycleh   = rf_val[22];
   assign rf_bus.minstretl = rf_val[23];
   assign rf_bus.minstreth = rf_val[24];
   assign rf_bus.mrac      = rf_val[25];

   el2_regfile_snapshot #(.MIN_GAP(MIN_GAP)) dut (
      .clk       (clk),
      .rst       (rst),
      .rf        (rf_bus),
      .req_trap  (req_trap),
      .req_sw    (req_sw),
      .mask      (mask),
      .drop_clr  (drop_clr),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_data  (out_data),
      .out_last  (out_last),
      .out_src   (out_src),
      .drop_cnt  (drop_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // outputs are checked mid-cycle, then the model advances by the effect of the coming edge
   always @(negedge clk) begin
      bit    exp_valid, was_busy;
      int    nt, dr, cnt, k;
      beat_t b;
      if (chk_en) begin
         exp_valid = (mq.size() > 0);
         chk("out_valid", 32'(out_valid), 32'(exp_valid));
         chk("busy", 32'(busy), 32'(exp_valid || (mgap > 0)));
         chk("drop_cnt", 32'(drop_cnt), 32'(mdrop));
         if (exp_valid && out_valid) begin
            chk("out_idx", 32'(out_idx), 32'(mq[0].idx));
            chk("out_data", out_data, mq[0].data);
            chk("out_last", 32'(out_last), 32'(mq[0].last));
            chk("out_src", 32'(out_src), 32'(mq[0].src));
         end
         if (out_valid && out_ready && !rst) begin
            b.idx = out_idx; b.data = out_data; b.last = out_last; b.src = out_src;
            log_q.push_back(b);
         end
      end
      if (rst) begin
         mq.delete();
         mgap  = 0;
         mdrop = 0;
      end else begin
         was_busy = (mq.size() > 0) || (mgap > 0);
         nt = int'(req_trap) + int'(req_sw);
         dr = nt;
         if (mq.size() > 0) begin
            if (out_ready) begin
               void'(mq.pop_front());
               if (mq.size() == 0) mgap = MIN_GAP;
            end
         end else if (mgap > 0) begin
            mgap--;
         end
         if (!was_busy && nt > 0 && mask != 26'd0) begin
            cnt = $countones(mask);
            k   = 0;
            for (int i = 0; i < 26; i++) begin
               if (mask[i]) begin
                  k++;
                  b.idx = 5'(i); b.data = rf_val[i]; b.last = (k == cnt); b.src = req_trap;
                  mq.push_back(b);
               end
            end
            dr = nt - 1;
         end
         mdrop = drop_clr ? 0 : ((mdrop + dr > 255) ? 255 : mdrop + dr);
      end
   end

   initial begin
      rst = 1'b1; req_trap = 1'b0; req_sw = 1'b0; drop_clr = 1'b0; out_ready = 1'b0; mask = '0;
      for (int i = 0; i < 26; i++) rf_val[i] = 32'd0;
      repeat (3) cyc();
      chk_en = 1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_idx", 32'(out_idx), 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_src", 32'(out_src), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      cyc();

      // full sweep, software source
      for (int i = 0; i < 26; i++) rf_val[i] = 32'hA500_0000 | 32'(i * 17 + 3);
      log_q.delete();
      mask = 26'h3FF_FFFF; out_ready = 1'b1; req_sw = 1'b1;
      cyc();
      req_sw = 1'b0;
      repeat (40) cyc();
      chk("t1_beats", 32'(log_q.size()), 32'd26);
      for (int k = 0; k < 26; k++) begin
         if (k < log_q.size()) begin
            chk("t1_idx", 32'(log_q[k].idx), 32'(k));
            chk("t1_data", log_q[k].data, 32'hA500_0000 | 32'(k * 17 + 3));
            chk("t1_last", 32'(log_q[k].last), 32'(k == 25));
            chk("t1_src", 32'(log_q[k].src), 32'd0);
         end
      end

      // simultaneous trap and sw
      log_q.delete();
      mask = 26'h000_0801; req_trap = 1'b1; req_sw = 1'b1;
      cyc();
      req_trap = 1'b0; req_sw = 1'b0;
      repeat (12) cyc();
      chk("t2_beats", 32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         chk("t2_idx0", 32'(log_q[0].idx), 32'd0);
         chk("t2_idx1", 32'(log_q[1].idx), 32'd11);
         chk("t2_src0", 32'(log_q[0].src), 32'd1);
         chk("t2_src1", 32'(log_q[1].src), 32'd1);
         chk("t2_last", 32'(log_q[1].last), 32'd1);
      end
      chk("t2_drop", 32'(drop_cnt), 32'd1);

      // stalled sink, register file changing after capture
      drop_clr = 1'b1;
      cyc();
      drop_clr = 1'b0;
      for (int i = 0; i < 26; i++) rf_val[i] = 32'hB000_0000 + 32'(i);
      log_q.delete();
      mask = 26'h200_0004; out_ready = 1'b0; req_sw = 1'b1;
      cyc();
      req_sw = 1'b0;
      for (int i = 0; i < 26; i++) rf_val[i] = 32'hDEAD_0000 + 32'(i);
      out_ready = 1'b1;
      cyc();
      out_ready = 1'b0;
      cyc();
      chk("t3_stall_idx", 32'(out_idx), 32'd25);
      chk("t3_stall_data", out_data, 32'hB000_0019);
      cyc();
      out_ready = 1'b1;
      cyc();
      repeat (8) cyc();
      chk("t3_beats", 32'(log_q.size()), 32'd2);
      if (log_q.size() == 2) begin
         chk("t3_data0", log_q[0].data, 32'hB000_0002);
         chk("t3_data1", log_q[1].data, 32'hB000_0019);
         chk("t3_idx1", 32'(log_q[1].idx), 32'd25);
         chk("t3_last1", 32'(log_q[1].last), 32'd1);
      end

      // gap enforcement: triggers in L..L+4 dropped, L+5 accepted
      log_q.delete();
      mask = 26'h000_0010; req_sw = 1'b1;
      cyc();
      repeat (5) cyc();
      chk("t4_busy_l5", 32'(busy), 32'd0);
      cyc();
      req_sw = 1'b0;
      chk("t4_busy_l6", 32'(busy), 32'd1);
      repeat (10) cyc();
      chk("t4_drop", 32'(drop_cnt), 32'd5);
      chk("t4_beats", 32'(log_q.size()), 32'd2);
      mask = '0; req_sw = 1'b1;
      repeat (300) cyc();
      req_sw = 1'b0;
      cyc();
      chk("t4_sat", 32'(drop_cnt), 32'd255);

      // zero-mask trigger and clear priority
      drop_clr = 1'b1;
      cyc();
      drop_clr = 1'b0;
      log_q.delete();
      mask = '0; req_trap = 1'b1;
      cyc();
      req_trap = 1'b0;
      chk("t5_drop", 32'(drop_cnt), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      cyc();
      chk("t5_beats", 32'(log_q.size()), 32'd0);
      drop_clr = 1'b1; req_sw = 1'b1;
      cyc();
      drop_clr = 1'b0; req_sw = 1'b0;
      chk("t5_clr", 32'(drop_cnt), 32'd0);

      // reset mid-stream after three beats
      req_sw = 1'b1;
      cyc();
      log_q.delete();
      mask = 26'h3FF_FFFF; out_ready = 1'b1;
      cyc();
      req_sw = 1'b0;
      cyc();
      cyc();
      cyc();
      out_ready = 1'b0; rst = 1'b1;
      cyc();
      rst = 1'b0; out_ready = 1'b1;
      chk("t6_valid", 32'(out_valid), 32'd0);
      chk("t6_busy", 32'(busy), 32'd0);
      chk("t6_drop", 32'(drop_cnt), 32'd0);
      chk("t6_beats", 32'(log_q.size()), 32'd3);
      mask = 26'h3FF_FFF0; req_sw = 1'b1;
      cyc();
      req_sw = 1'b0;
      chk("t6_fresh_valid", 32'(out_valid), 32'd1);
      chk("t6_fresh_idx", 32'(out_idx), 32'd4);
      repeat (30) cyc();

      $display("[TB] %0d tests run, %0d failed", tests_run, failed);
      $finish;
   end

endmodule

// File: doc/el2_regfile_snapshot.md
# el2_regfile_snapshot

Trigger-driven snapshot controller for the exposed architectural register set (11 GPRs plus 15 PC/CSR values) carried on `el2_regfile_if`. On an accepted software or trap trigger it captures all 26 words atomically into a shadow bank. It then streams the selected words out one per cycle on a valid/ready port tagged with a register index. It sits beside the core as a sink of the register-file interface, feeding trace/debug logic, and arbitrates between two trigger requesters.

## Interface
Parameters:
- `MIN_GAP`, 4: idle cycles enforced after a stream completes before a new trigger is accepted (0..255).

Ports:
- `clk`  in  1  core clock. Single clock; reset is synchronous and active-high.
- `rst`  in  1  synchronous, active-high reset.
- `rf`  in  `el2_regfile_if.veer_rf_sink`  exposed register values, sampled combinationally.
- `req_trap`  in  1  trap trigger pulse, high priority.
- `req_sw`  in  1  software trigger pulse, low priority.
- `mask`  in  26  word-select mask; bit n = register index n; sampled with the trigger.
- `drop_clr`  in  1  clears `drop_cnt`.
- `busy`  out  1  high in STREAM and GAP.
- `out_valid`  out  1  beat valid.
- `out_ready`  in  1  sink ready.
- `out_idx`  out  5  register index of the beat.
- `out_data`  out  32  register value.
- `out_last`  out  1  final beat of the snapshot.
- `out_src`  out  1  0 = sw, 1 = trap; constant for the whole snapshot.
- `drop_cnt`  out  8  saturating count of dropped triggers.

## Operation
- Index map:
  - GPRs: ra=0, sp=1, fp=2, a0..a7=3..10.
  - PC/CSR: pc=11, npc=12, mstatus=13, mie=14, mtvec=15, mscratch=16, mepc=17, mcause=18, mtval=19, mip=20, mcyclel=21, mcycleh=22, minstretl=23, minstreth=24, mrac=25.
- FSM states are IDLE, STREAM and GAP.
- IDLE, trigger present, `mask != 0`:
  - Load all 26 shadow words and the pending mask.
  - Latch `out_src`; trap wins if both triggers are present.
  - Go to STREAM.
- IDLE, trigger present, `mask == 0`: trigger is not accepted and counts as dropped; stay in IDLE.
- STREAM, beat selection: the lowest set bit of the pending mask drives `out_idx`/`out_data`. `out_last` is high when exactly one bit remains.
- STREAM, handshake (`out_valid & out_ready`): clear that bit.
  - If the beat was last: go to GAP when `MIN_GAP>0`, otherwise to IDLE.
- GAP: count down `MIN_GAP` cycles, then go to IDLE.
- Dropped triggers:
  - Any trigger seen while not in IDLE.
  - The losing sw trigger on a simultaneous accept.
  - Any zero-mask trigger.
- `drop_cnt` adds the number of triggers dropped this cycle (0, 1 or 2) and saturates at 255. `drop_clr` wins over an increment in the same cycle, so the result is 0.
- Register values that change after capture never affect the streamed data.

## Timing
- Reset values:
  - State is IDLE.
  - `busy`, `out_valid`, `out_last`, `out_src` = 0; `out_idx` = 0; `out_data` = 0.
  - `drop_cnt` = 0; shadow bank = 0.
- Trigger accepted in cycle T:
  - Shadow holds the cycle-T values of `rf`.
  - `out_valid` and `busy` are high from T+1.
- Handshake rules:
  - One beat per cycle with `out_ready` held high.
  - While `out_valid & !out_ready`, `out_idx`, `out_data`, `out_last` and `out_src` hold stable and `out_valid` stays high.
- Last handshake in cycle L:
  - `out_valid` is low at L+1.
  - `busy` drops at L+1 when `MIN_GAP=0`, otherwise at L+1+`MIN_GAP`.
  - A trigger in cycle L is dropped.
- The first new trigger is accepted in the first cycle where `busy=0`.
- Reset mid-stream: outputs take reset values at the next edge. The stream is abandoned with no `out_last`.

## Structure
- `el2_pkg` additions:
  - Localparams `RF_IDX_RA`..`RF_IDX_MRAC` and `RF_SNAP_NUM=26`.
  - Typedef `el2_rf_snap_state_t` {IDLE, STREAM, GAP}.
- Sub-module `el2_rf_snap_penc`: combinational 26-bit find-first-set with outputs `idx[4:0]`, `any`, `one_left`.
- The shadow bank is a flat array indexed by the package constants, loaded from `rf` in index order.

## Test plan
- `req_sw` with mask=0x3FFFFFF, `out_ready`=1, distinct value per register: 26 beats at idx 0..25 on consecutive cycles; `out_last` only on idx 25; `out_src`=0.
- `req_trap` and `req_sw` in the same cycle, mask=0x0000801 (ra, pc): beats idx 0 then 11 with `out_src`=1; `drop_cnt`=1.
- Mask=0x2000004, `out_ready` toggling 1-0-0-1, `rf` changed after capture: data holds stable while stalled and equals the capture-cycle values; `out_last` on idx 25.
- `MIN_GAP`=4, single-bit mask: trigger at L+1..L+4 is dropped; trigger at L+5 is accepted; `drop_cnt` increments per dropped pulse; 300 drops → 255.
- Zero-mask trigger: no beats, `busy` stays 0, `drop_cnt`+1; `drop_clr` asserted with a drop in the same cycle → 0.
- `rst` asserted mid-stream after 3 beats: next cycle `out_valid`=0, `busy`=0, `drop_cnt`=0; a fresh trigger streams from the lowest masked index.
